// File: rtl/nodf_module_status_tracker.sv
// Passive status tracker for one ap_ctrl_hs/chain HLS block: state, transaction counts, latency, interval, stalls.
// Define NODF_LATENCY_MINMAX_EN to add min_latency/max_latency outputs.
module nodf_module_status_tracker #(
    parameter int CNT_W = 32,
    parameter int LAT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ap_start,
    input  logic             ap_ready,
    input  logic             ap_done,
    input  logic             ap_continue,
    input  logic             finish,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] start_cnt,
    output logic [CNT_W-1:0] done_cnt,
    output logic [LAT_W-1:0] last_latency,
    output logic [LAT_W-1:0] last_interval,
    output logic [LAT_W-1:0] stall_cycles,
    output logic             lat_valid,
    output logic             finished
`ifdef NODF_LATENCY_MINMAX_EN
    ,
    output logic [LAT_W-1:0] min_latency,
    output logic [LAT_W-1:0] max_latency
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_FIN  = 2'd3;

    localparam logic [LAT_W-1:0] LAT_ONE = {{(LAT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       cur_st;
    logic [1:0]       nxt_st;
    logic [LAT_W-1:0] lat_tmr;
    logic [LAT_W-1:0] ivl_tmr;
    logic [LAT_W-1:0] lat_now;
    logic             run;
    logic             active;
    logic             accept;
    logic             retire;
    logic             stall;

    function automatic logic [LAT_W-1:0] inc_l(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + LAT_ONE;
    endfunction

    function automatic logic [CNT_W-1:0] inc_c(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Handshake: a start is accepted when ap_start&ap_ready, a transaction retires when
    // ap_done&ap_continue; both are only observed here. ap_done in IDLE counts only if ap_start is up.
    always_comb begin
        run     = (cur_st != S_FIN) && !finish;
        active  = (cur_st == S_BUSY) || (cur_st == S_WAIT) || ((cur_st == S_IDLE) && ap_start);
        accept  = ap_start && ap_ready;
        retire  = active && ap_done && ap_continue;
        stall   = active && ap_done && !ap_continue;
        lat_now = (cur_st == S_IDLE) ? LAT_ONE : inc_l(lat_tmr);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_st <= S_IDLE;
        end else begin
            cur_st <= nxt_st;
        end
    end

    always_comb begin
        nxt_st = cur_st;
        if (cur_st != S_FIN) begin
            if (finish) begin
                nxt_st = S_FIN;
            end else if (active) begin
                if (retire) begin
                    // Same-cycle start+done from IDLE is a complete transaction
                    nxt_st = ((cur_st != S_IDLE) && ap_start) ? S_BUSY : S_IDLE;
                end else if (stall) begin
                    nxt_st = S_WAIT;
                end else if (cur_st == S_IDLE) begin
                    nxt_st = S_BUSY;
                end
            end
        end
    end

    always_comb begin
        state    = cur_st;
        finished = (cur_st == S_FIN);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            start_cnt     <= '0;
            done_cnt      <= '0;
            last_latency  <= '0;
            last_interval <= '0;
            stall_cycles  <= '0;
            lat_tmr       <= '0;
            ivl_tmr       <= '0;
            lat_valid     <= 1'b0;
        end else if (run) begin
            // ivl_tmr stays 0 until the first accepted start, which keeps last_interval at 0
            if (accept) begin
                start_cnt <= inc_c(start_cnt);
                if (ivl_tmr != '0) begin
                    last_interval <= ivl_tmr;
                end
                ivl_tmr <= LAT_ONE;
            end else if (ivl_tmr != '0) begin
                ivl_tmr <= inc_l(ivl_tmr);
            end
            if (retire) begin
                done_cnt     <= inc_c(done_cnt);
                last_latency <= lat_now;
                lat_tmr      <= LAT_ONE;
            end else if (active) begin
                lat_tmr <= lat_now;
            end
            if (stall) begin
                stall_cycles <= inc_l(stall_cycles);
            end
            lat_valid <= retire;
        end else begin
            lat_valid <= 1'b0;
        end
    end

`ifdef NODF_LATENCY_MINMAX_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            min_latency <= '1;
            max_latency <= '0;
        end else if (run && retire) begin
            if (lat_now < min_latency) begin
                min_latency <= lat_now;
            end
            if (lat_now > max_latency) begin
                max_latency <= lat_now;
            end
        end
    end
`endif

endmodule

// File: tb/tb_nodf_module_status_tracker.sv
// Randomized scoreboard bench for nodf_module_status_tracker with a cycle-index reference model.
// Narrow counter widths are used so saturation is reached within the run.
module tb_nodf_module_status_tracker;

    localparam int CW   = 4;
    localparam int LW   = 6;
    localparam int CMAX = (1 << CW) - 1;
    localparam int LMAX = (1 << LW) - 1;

    logic          clock;
    logic          reset;
    logic          ap_start;
    logic          ap_ready;
    logic          ap_done;
    logic          ap_continue;
    logic          finish;
    logic [1:0]    state;
    logic [CW-1:0] start_cnt;
    logic [CW-1:0] done_cnt;
    logic [LW-1:0] last_latency;
    logic [LW-1:0] last_interval;
    logic [LW-1:0] stall_cycles;
    logic          lat_valid;
    logic          finished;
`ifdef NODF_LATENCY_MINMAX_EN
    logic [LW-1:0] min_latency;
    logic [LW-1:0] max_latency;
`endif

    nodf_module_status_tracker #(.CNT_W(CW), .LAT_W(LW)) dut (
        .clock(clock),
        .reset(reset),
        .ap_start(ap_start),
        .ap_ready(ap_ready),
        .ap_done(ap_done),
        .ap_continue(ap_continue),
        .finish(finish),
        .state(state),
        .start_cnt(start_cnt),
        .done_cnt(done_cnt),
        .last_latency(last_latency),
        .last_interval(last_interval),
        .stall_cycles(stall_cycles),
        .lat_valid(lat_valid),
        .finished(finished)
`ifdef NODF_LATENCY_MINMAX_EN
        ,
        .min_latency(min_latency),
        .max_latency(max_latency)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int st;
        int sc;
        int dc;
        int ll;
        int li;
        int sl;
        int lv;
        int fin;
        int mn;
        int mx;
    } snap_t;

    snap_t         snap_q[$];
    logic [LW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;

    // Reference model: state by name, times by absolute cycle index.
    int m_st, m_sc, m_dc, m_ll, m_li, m_sl, m_lv, m_mn, m_mx;
    int cyc, txn_start, prev_acc;
    bit have_prev;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        m_st = 0; m_sc = 0; m_dc = 0; m_ll = 0; m_li = 0; m_sl = 0; m_lv = 0;
        m_mn = LMAX; m_mx = 0;
        txn_start = 0; prev_acc = 0; have_prev = 0;
        snap_q.delete();
        exp_q.delete();
    endfunction

    function automatic void model_step(input bit s, input bit r, input bit d, input bit c, input bit f);
        snap_t e;
        bit    active;
        int    lat;
        m_lv = 0;
        if (m_st != 3) begin
            if (f) begin
                m_st = 3;
            end else begin
                active = (m_st != 0) || s;
                if (s && r) begin
                    if (have_prev) m_li = sat(cyc - prev_acc, LMAX);
                    prev_acc  = cyc;
                    have_prev = 1;
                    m_sc      = sat(m_sc + 1, CMAX);
                end
                if (active) begin
                    if (m_st == 0) txn_start = cyc;
                    if (d && c) begin
                        lat  = sat(cyc - txn_start + 1, LMAX);
                        m_ll = lat;
                        m_lv = 1;
                        exp_q.push_back(lat[LW-1:0]);
                        m_dc = sat(m_dc + 1, CMAX);
                        if (lat < m_mn) m_mn = lat;
                        if (lat > m_mx) m_mx = lat;
                        if (m_st != 0) begin
                            if (s) begin
                                m_st      = 1;
                                txn_start = cyc;
                            end else begin
                                m_st = 0;
                            end
                        end
                    end else if (d) begin
                        m_sl = sat(m_sl + 1, LMAX);
                        m_st = 2;
                    end else if (m_st == 0) begin
                        m_st = 1;
                    end
                end
            end
        end
        cyc++;
        e.st = m_st; e.sc = m_sc; e.dc = m_dc; e.ll = m_ll; e.li = m_li; e.sl = m_sl;
        e.lv = m_lv; e.fin = (m_st == 3) ? 1 : 0; e.mn = m_mn; e.mx = m_mx;
        snap_q.push_back(e);
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clock) begin
        snap_t e;
        #1;
        if (reset && snap_q.size() > 0) begin
            e = snap_q.pop_front();
            chk("state", state, e.st);
            chk("start_cnt", start_cnt, e.sc);
            chk("done_cnt", done_cnt, e.dc);
            chk("last_latency", last_latency, e.ll);
            chk("last_interval", last_interval, e.li);
            chk("stall_cycles", stall_cycles, e.sl);
            chk("lat_valid", lat_valid, e.lv);
            chk("finished", finished, e.fin);
`ifdef NODF_LATENCY_MINMAX_EN
            chk("min_latency", min_latency, e.mn);
            chk("max_latency", max_latency, e.mx);
`endif
            if (lat_valid) begin
                if (exp_q.size() == 0) begin
                    chk("lat_pulse_unexpected", lat_valid, 0);
                end else begin
                    chk("lat_pulse_value", last_latency, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit s, input bit r, input bit d, input bit c, input bit f);
        @(negedge clock);
        ap_start = s; ap_ready = r; ap_done = d; ap_continue = c; finish = f;
        model_step(s, r, d, c, f);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clock);
        #2;
    endtask

    // Transaction of len cycles from accepted start to retire, inclusive
    task automatic txn(input int len);
        if (len == 1) begin
            step(1, 1, 1, 1, 0);
        end else begin
            step(1, 1, 0, 0, 0);
            idle(len - 2);
            step(0, 0, 1, 1, 0);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_start_cnt"}, start_cnt, 0);
        chk({tag, "_done_cnt"}, done_cnt, 0);
        chk({tag, "_last_latency"}, last_latency, 0);
        chk({tag, "_last_interval"}, last_interval, 0);
        chk({tag, "_stall_cycles"}, stall_cycles, 0);
        chk({tag, "_lat_valid"}, lat_valid, 0);
        chk({tag, "_finished"}, finished, 0);
`ifdef NODF_LATENCY_MINMAX_EN
        chk({tag, "_min_latency"}, min_latency, LMAX);
        chk({tag, "_max_latency"}, max_latency, 0);
`endif
    endtask

    // Asserts reset between clock edges and checks outputs clear without waiting for a clock
    task automatic async_reset(input string tag);
        @(negedge clock);
        ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0;
        #2 reset = 1'b0;
        #1 check_zero(tag);
        model_reset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 0; finish = 0;
        cyc = 0;
        model_reset();
        #1 check_zero("por");
        repeat (2) @(negedge clock);
        reset = 1'b1;

        // single transaction, latency 5
        txn(5);
        settle();
        chk("t1_latency", last_latency, 5);
        chk("t1_lat_valid", lat_valid, 1);
        chk("t1_start_cnt", start_cnt, 1);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_state", state, 0);
        idle(2);

        // accepted starts 7 cycles apart
        async_reset("rst_t2");
        step(1, 1, 0, 0, 0);
        idle(6);
        step(1, 1, 0, 0, 0);
        settle();
        chk("t2_interval", last_interval, 7);
        chk("t2_start_cnt", start_cnt, 2);
        idle(2);

        // stall for 3 cycles before continue; reset lands mid-BUSY
        async_reset("rst_busy");
        step(1, 1, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        settle();
        chk("t3_stall", stall_cycles, 3);
        chk("t3_latency", last_latency, 6);
        idle(1);

        // start and done in the same IDLE cycle
        async_reset("rst_t4");
        step(1, 1, 1, 1, 0);
        settle();
        chk("t4_latency", last_latency, 1);
        chk("t4_state", state, 0);
        idle(1);

        // back-to-back retire with new start, then latency saturation
        async_reset("rst_t5");
        step(1, 1, 0, 0, 0);
        idle(2);
        step(1, 1, 1, 1, 0);
        idle(2);
        step(0, 0, 1, 1, 0);
        txn(70);
        settle();
        chk("sat_latency", last_latency, LMAX);
        idle(1);

        // min/max over latencies 5, 2, 9
        async_reset("rst_mm");
        txn(5);
        txn(2);
        txn(9);
        settle();
`ifdef NODF_LATENCY_MINMAX_EN
        chk("mm_min", min_latency, 2);
        chk("mm_max", max_latency, 9);
`endif
        chk("mm_done_cnt", done_cnt, 3);
        idle(1);

        // finish mid-transaction freezes everything
        async_reset("rst_fin");
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        settle();
        chk("fin_state", state, 3);
        chk("fin_flag", finished, 1);
        chk("fin_start_cnt", start_cnt, 1);
        chk("fin_done_cnt", done_cnt, 0);
        chk("fin_stall", stall_cycles, 0);

        // randomized traffic, including counter saturation and a mid-run reset
        async_reset("rst_rand");
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset("rst_mid");
            step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 65, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            step($urandom_range(0, 99) < 50, $urandom_range(0, 99) < 60,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 65, i == 20);
        end
        settle();
        chk("rand_finished", finished, 1);
        chk("snap_q_drained", snap_q.size(), 0);
        chk("lat_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
